// File: rtl/mext_pkg.sv
// mext_pkg: shared definitions for the RV32M multiply/divide sequencer.
//   - 5-bit alu_opE encodings of the eight M-extension ops
//   - 2-bit opcode encodings driven to the multiplier and the divider
//   - sequencer state enum and the RISC-V special-case result constants
//   - helpers to recognise an M-op and split it into unit select + opcode
package mext_pkg;

   localparam logic [4:0] ALU_MUL    = 5'b01011;
   localparam logic [4:0] ALU_MULH   = 5'b01100;
   localparam logic [4:0] ALU_MULHSU = 5'b01101;
   localparam logic [4:0] ALU_MULHU  = 5'b01110;
   localparam logic [4:0] ALU_DIV    = 5'b01111;
   localparam logic [4:0] ALU_DIVU   = 5'b10000;
   localparam logic [4:0] ALU_REM    = 5'b10001;
   localparam logic [4:0] ALU_REMU   = 5'b10010;

   localparam logic [1:0] MUL_OP_MUL    = 2'b00;
   localparam logic [1:0] MUL_OP_MULH   = 2'b01;
   localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
   localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [1:0] DIV_OP_REM  = 2'b10;
   localparam logic [1:0] DIV_OP_REMU = 2'b11;

   localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN       = 32'h8000_0000;

   typedef enum logic [2:0] {
      IDLE, ISSUE, BUSY, RESP, DRAIN
   } mds_state_t;

   // Decoded M-op: which unit, and the opcode that unit expects.
   typedef struct packed {
      logic       is_div;
      logic [1:0] code;
   } mop_dec_t;

   // M-ops occupy the contiguous range MUL..REMU.
   function automatic logic is_mop(input logic [4:0] op);
      return (op >= ALU_MUL) && (op <= ALU_REMU);
   endfunction

   // Both groups are laid out in the same order as their unit opcodes,
   // so the unit opcode is the offset from the first op of the group.
   function automatic mop_dec_t decode_mop(input logic [4:0] op);
      mop_dec_t   d;
      logic [4:0] off;
      d.is_div = (op >= ALU_DIV);
      off      = d.is_div ? (op - ALU_DIV) : (op - ALU_MUL);
      d.code   = off[1:0];
      return d;
   endfunction

endpackage

// File: rtl/muldiv_special_case.sv
// muldiv_special_case: combinational detector for divide cases whose
// result is fixed by the RISC-V spec, so the divider need not be started.
//   div_opcode  in  2   divider opcode (DIV/DIVU/REM/REMU)
//   dividend    in  32  operand A
//   divisor     in  32  operand B
//   hit         out 1   a fixed result applies
//   result      out 32  the fixed result (0 when hit is low)
module muldiv_special_case
   import mext_pkg::*;
(
   input  logic [1:0]  div_opcode,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        hit,
   output logic [31:0] result
);

   logic is_rem;
   logic is_signed;

   assign is_rem    = (div_opcode == DIV_OP_REM) || (div_opcode == DIV_OP_REMU);
   assign is_signed = (div_opcode == DIV_OP_DIV) || (div_opcode == DIV_OP_REM);

   always_comb begin
      hit    = 1'b0;
      result = '0;
      if (divisor == '0) begin
         hit    = 1'b1;
         result = is_rem ? dividend : DIV_BY_ZERO_Q;
      end else if (is_signed && dividend == INT_MIN && divisor == 32'hFFFF_FFFF) begin
         // Signed overflow: quotient wraps to INT_MIN, remainder is zero.
         hit    = 1'b1;
         result = is_rem ? '0 : INT_MIN;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: execute-stage controller for RV32M ops. Captures one
// M-op, pulses the start of the iterative multiplier or divider, stalls the
// pipeline while it runs and returns the result with a one-cycle flag.
//   clk, rst                 clock, synchronous active-high reset
//   startE, alu_opE          valid instruction in execute and its ALU op
//   SrcAE, SrcBE             operands
//   flushE                   kill the instruction in execute
//   stallM                   hold the pipeline upstream of execute
//   flagM, result_m          one-cycle result valid and result
//   mul_start/opcode/done/result   multiplier handshake
//   div_start/opcode/done/result   divider handshake
//   operand1, operand2       registered operands shared by both units
module muldiv_sequencer
   import mext_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        startE,
   input  logic [4:0]  alu_opE,
   input  logic [31:0] SrcAE,
   input  logic [31:0] SrcBE,
   input  logic        flushE,
   output logic        stallM,
   output logic        flagM,
   output logic [31:0] result_m,
   output logic        mul_start,
   output logic [1:0]  mul_opcode,
   input  logic        mul_done,
   input  logic [31:0] mul_result,
   output logic        div_start,
   output logic [1:0]  div_opcode,
   input  logic        div_done,
   input  logic [31:0] div_result,
   output logic [31:0] operand1,
   output logic [31:0] operand2
);

   mds_state_t  state;
   mop_dec_t    dec;
   logic        mop;
   logic        accept;
   logic        sc_hit;
   logic [31:0] sc_result;
   logic        fast;
   logic        is_div_q;
   logic        flag_q;
   logic [31:0] result_q;
   logic        sel_done;
   logic [31:0] sel_result;

   assign mop    = is_mop(alu_opE);
   assign dec    = decode_mop(alu_opE);
   assign accept = (state == IDLE) && startE && mop && !flushE;

   muldiv_special_case u_special (
      .div_opcode (dec.code),
      .dividend   (SrcAE),
      .divisor    (SrcBE),
      .hit        (sc_hit),
      .result     (sc_result)
   );

   // The detector only knows divide semantics; ignore it for mul ops.
   assign fast = dec.is_div && sc_hit;

   // Only the unit we started is listened to; the other one's done is noise.
   assign sel_done   = is_div_q ? div_done   : mul_done;
   assign sel_result = is_div_q ? div_result : mul_result;

   always_comb begin
      stallM = 1'b0;
      case (state)
         IDLE:        stallM = accept;
         ISSUE, BUSY: stallM = 1'b1;
         DRAIN:       stallM = startE && mop;
         default:     stallM = 1'b0;
      endcase
   end

   // The flag is registered on entry to RESP; a flush landing in that same
   // cycle still has to suppress it, so the kill is applied on the way out.
   assign flagM    = flag_q && !flushE;
   assign result_m = flagM ? result_q : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mul_start  <= 1'b0;
         div_start  <= 1'b0;
         mul_opcode <= '0;
         div_opcode <= '0;
         operand1   <= '0;
         operand2   <= '0;
         is_div_q   <= 1'b0;
         flag_q     <= 1'b0;
         result_q   <= '0;
      end else begin
         mul_start <= 1'b0;
         div_start <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  operand1 <= SrcAE;
                  operand2 <= SrcBE;
                  is_div_q <= dec.is_div;
                  if (dec.is_div) div_opcode <= dec.code;
                  else            mul_opcode <= dec.code;
                  if (fast) begin
                     result_q <= sc_result;
                     flag_q   <= 1'b1;
                     state    <= RESP;
                  end else begin
                     mul_start <= !dec.is_div;
                     div_start <= dec.is_div;
                     state     <= ISSUE;
                  end
               end
            end
            // The start pulse is already on the wire; a flush here only
            // means its eventual result must be thrown away.
            ISSUE: state <= flushE ? DRAIN : BUSY;
            BUSY: begin
               if (flushE) begin
                  state <= sel_done ? IDLE : DRAIN;
               end else if (sel_done) begin
                  result_q <= sel_result;
                  flag_q   <= 1'b1;
                  state    <= RESP;
               end
            end
            RESP: begin
               flag_q   <= 1'b0;
               result_q <= '0;
               state    <= IDLE;
            end
            DRAIN: if (sel_done) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
   import mext_pkg::*;

   logic        clk = 1'b0;
   logic        rst, startE, flushE;
   logic [4:0]  alu_opE;
   logic [31:0] SrcAE, SrcBE;
   logic        stallM, flagM, mul_start, div_start, mul_done, div_done;
   logic [31:0] result_m, mul_result, div_result, operand1, operand2;
   logic [1:0]  mul_opcode, div_opcode;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   muldiv_sequencer dut (
      .clk(clk), .rst(rst), .startE(startE), .alu_opE(alu_opE),
      .SrcAE(SrcAE), .SrcBE(SrcBE), .flushE(flushE), .stallM(stallM),
      .flagM(flagM), .result_m(result_m), .mul_start(mul_start),
      .mul_opcode(mul_opcode), .mul_done(mul_done), .mul_result(mul_result),
      .div_start(div_start), .div_opcode(div_opcode), .div_done(div_done),
      .div_result(div_result), .operand1(operand1), .operand2(operand2)
   );

   // Architectural result of an M-op, straight from the ISA definition.
   function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint ua = longint'({32'b0, a});
      longint ub = longint'({32'b0, b});
      logic [63:0] p;
      logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         ALU_MUL:    begin p = sa * sb; return p[31:0];  end
         ALU_MULH:   begin p = sa * sb; return p[63:32]; end
         ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
         ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
         ALU_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; if (ovf) return 32'h8000_0000; p = sa / sb; return p[31:0]; end
         ALU_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
         ALU_REM:    begin if (b == 0) return a; if (ovf) return 32'h0; p = sa % sb; return p[31:0]; end
         ALU_REMU:   begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
         default:    return 32'h0;
      endcase
   endfunction

   // Unit models: done arrives lat cycles after the start edge; the result
   // is computed from whatever opcode/operands the sequencer holds at done.
   int         mlat = 1, dlat = 1;
   logic [5:0] mcnt, dcnt;
   logic       force_div;
   always @(posedge clk) begin
      if (rst) begin
         mcnt <= '0; dcnt <= '0;
      end else begin
         if (mul_start) mcnt <= 6'(mlat); else if (mcnt != 0) mcnt <= mcnt - 1'b1;
         if (div_start) dcnt <= 6'(dlat); else if (dcnt != 0) dcnt <= dcnt - 1'b1;
      end
   end
   assign mul_done   = (mcnt == 6'd1);
   assign div_done   = (dcnt == 6'd1) || force_div;
   assign mul_result = mul_done ? ref_model(ALU_MUL + {3'b0, mul_opcode}, operand1, operand2) : 32'hDEAD_BEEF;
   assign div_result = (dcnt == 6'd1) ? ref_model(ALU_DIV + {3'b0, div_opcode}, operand1, operand2) : 32'hDEAD_BEEF;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Called mid-cycle with the sequencer idle; presents one M-op, holds it
   // until the flag cycle and returns mid-cycle in the following IDLE cycle.
   task automatic run_op(input string nm, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] exp, input bit fast, input logic [1:0] code, input bit stray);
      int starts = 0, start_cyc = -1, flag_cyc = -1;
      bit stall_ok = 1, zero_ok = 1;
      logic [1:0]  got_code = 2'bxx;
      logic [31:0] got = 32'hxxxx_xxxx;
      mlat = lat; dlat = lat;
      startE = 1'b1; alu_opE = op; SrcAE = a; SrcBE = b;
      #1 check({nm, " stall_accept"}, 32'(stallM), 32'd1);
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(negedge clk);
         force_div = stray && (cyc == 3);
         #1;
         if (mul_start || div_start) begin
            starts++; start_cyc = cyc;
            got_code = mul_start ? mul_opcode : div_opcode;
         end
         if (flagM) begin
            flag_cyc = cyc; got = result_m;
            check({nm, " stall_flagcyc"}, 32'(stallM), 32'd0);
            break;
         end
         if (!stallM) stall_ok = 0;
         if (result_m != 0) zero_ok = 0;
      end
      force_div = 1'b0;
      @(negedge clk);
      startE = 1'b0;
      check({nm, " stall_window"}, 32'(stall_ok), 32'd1);
      check({nm, " result_zero_when_idle"}, 32'(zero_ok), 32'd1);
      check({nm, " start_count"}, starts, fast ? 0 : 1);
      if (!fast) begin
         check({nm, " start_cycle"}, start_cyc, 1);
         check({nm, " unit_opcode"}, 32'(got_code), 32'(code));
      end
      check({nm, " flag_cycle"}, flag_cyc, fast ? 1 : lat + 2);
      check({nm, " result"}, got, exp);
   endtask

   typedef struct {
      string       nm;
      logic [4:0]  op;
      logic [31:0] a, b;
      int          lat;
      logic [31:0] exp;
      bit          fast;
      logic [1:0]  code;
      bit          stray;
   } vec_t;

   vec_t vecs[12];

   initial begin
      vecs[0]  = '{"mul7x6",      ALU_MUL,    32'd7,          32'd6,          32, 32'd42,         0, 2'b00, 0};
      vecs[1]  = '{"mulh_m1",     ALU_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5,  32'h0,          0, 2'b01, 0};
      vecs[2]  = '{"divu100_7",   ALU_DIVU,   32'd100,        32'd7,          6,  32'd14,         0, 2'b01, 0};
      vecs[3]  = '{"rem_m7_2",    ALU_REM,    32'hFFFF_FFF9,  32'd2,          4,  32'hFFFF_FFFF,  0, 2'b10, 0};
      vecs[4]  = '{"div5_0",      ALU_DIV,    32'd5,          32'd0,          4,  32'hFFFF_FFFF,  1, 2'b00, 0};
      vecs[5]  = '{"remu5_0",     ALU_REMU,   32'd5,          32'd0,          4,  32'd5,          1, 2'b11, 0};
      vecs[6]  = '{"div_ovf",     ALU_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  4,  32'h8000_0000,  1, 2'b00, 0};
      vecs[7]  = '{"rem_ovf",     ALU_REM,    32'h8000_0000,  32'hFFFF_FFFF,  4,  32'h0,          1, 2'b10, 0};
      vecs[8]  = '{"mulhu_m1",    ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  3,  32'hFFFF_FFFE,  0, 2'b11, 0};
      vecs[9]  = '{"mulhsu_m1_2", ALU_MULHSU, 32'hFFFF_FFFF,  32'd2,          2,  32'hFFFF_FFFF,  0, 2'b10, 0};
      vecs[10] = '{"divu_intmin", ALU_DIVU,   32'h8000_0000,  32'hFFFF_FFFF,  3,  32'h0,          0, 2'b01, 0};
      vecs[11] = '{"mul_stray",   ALU_MUL,    32'd3,          32'd5,          8,  32'd15,         0, 2'b00, 1};

      rst = 1'b1; startE = 1'b0; flushE = 1'b0; alu_opE = '0; SrcAE = '0; SrcBE = '0; force_div = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_ctl", 32'({stallM, flagM, mul_start, div_start, mul_opcode, div_opcode}), 32'd0);
      check("reset_data", result_m | operand1 | operand2, 32'd0);
      @(negedge clk);

      foreach (vecs[i])
         run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].exp,
                vecs[i].fast, vecs[i].code, vecs[i].stray);

      // Flush in BUSY at cycle 5, second MUL waits through DRAIN.
      begin
         int starts = 0, st2 = -1, flag_cyc = -1, nflags = 0;
         bit stall_ok = 1;
         logic [31:0] got = '0;
         mlat = 10;
         startE = 1'b1; alu_opE = ALU_MUL; SrcAE = 32'd4; SrcBE = 32'd5;
         #1 check("flush stall_accept", 32'(stallM), 32'd1);
         for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (cyc == 5) begin flushE = 1'b1; startE = 1'b0; end
            if (cyc == 6) begin flushE = 1'b0; startE = 1'b1; SrcAE = 32'd6; SrcBE = 32'd7; mlat = 4; end
            #1;
            if (mul_start) begin starts++; if (cyc != 1) st2 = cyc; end
            if (cyc >= 6 && cyc <= 12 && !stallM) stall_ok = 0;
            if (flagM) begin nflags++; flag_cyc = cyc; got = result_m; break; end
         end
         @(negedge clk);
         startE = 1'b0;
         check("flush drain_stall", 32'(stall_ok), 32'd1);
         check("flush start_count", starts, 2);
         check("flush second_start_cycle", st2, 13);
         check("flush flag_cycle", flag_cyc, 18);
         check("flush result", got, 32'd42);
      end

      // done and flushE in the same BUSY cycle.
      begin
         bit flag_seen = 0;
         mlat = 5;
         startE = 1'b1; alu_opE = ALU_MUL; SrcAE = 32'd2; SrcBE = 32'd2;
         #1 check("doneflush stall_accept", 32'(stallM), 32'd1);
         for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            if (cyc == 6) begin flushE = 1'b1; startE = 1'b0; end
            if (cyc == 7) flushE = 1'b0;
            #1;
            if (flagM) flag_seen = 1;
         end
         check("doneflush no_flag", 32'(flag_seen), 32'd0);
         run_op("after_doneflush", ALU_MUL, 32'd3, 32'd4, 3, 32'd12, 0, 2'b00, 0);
      end

      // Reset in the middle of BUSY.
      begin
         mlat = 20;
         startE = 1'b1; alu_opE = ALU_MUL; SrcAE = 32'h1234; SrcBE = 32'h55;
         for (int cyc = 1; cyc <= 5; cyc++) @(negedge clk);
         rst = 1'b1; startE = 1'b0;
         @(negedge clk);
         rst = 1'b0;
         #1;
         check("midreset ctl", 32'({stallM, flagM, mul_start, div_start, mul_opcode, div_opcode}), 32'd0);
         check("midreset data", result_m | operand1 | operand2, 32'd0);
         run_op("mul3x3", ALU_MUL, 32'd3, 32'd3, 4, 32'd9, 0, 2'b00, 0);
      end

      // Random ops against the architectural model.
      for (int n = 0; n < 40; n++) begin
         logic [4:0]  op;
         logic [31:0] a, b;
         bit fast;
         logic [1:0] code;
         op = ALU_MUL + 5'($urandom_range(0, 7));
         a = $urandom; b = $urandom;
         case ($urandom_range(0, 9))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 9));
            default: ;
         endcase
         case (op)
            ALU_MUL, ALU_DIV:   code = 2'b00;
            ALU_MULH, ALU_DIVU: code = 2'b01;
            ALU_MULHSU, ALU_REM: code = 2'b10;
            default:            code = 2'b11;
         endcase
         fast = (op >= ALU_DIV) &&
                ((b == 0) || ((op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
         run_op($sformatf("rand%0d", n), op, a, b, $urandom_range(1, 8), ref_model(op, a, b), fast, code, 0);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
